// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data ports share one memory interface.
// Each access takes an IDLE grant cycle followed by a WAIT response cycle.
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wd,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic        win_i, win_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        win_i    = 1'b0;
        win_d    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        mem_we   = 1'b0;
        mem_wd   = 32'h0;
        mem_addr = addr_q;
        unique case (state_q)
            IDLE: begin
                // last_q=0 means fetch won last time, so data wins a tie
                win_d = d_req && (!i_req || FIXED_PRIO || !last_q);
                win_i = i_req && !win_d;
                if (win_d) begin
                    mem_addr = d_addr;
                    mem_we   = d_we;
                    mem_wd   = d_wd;
                end else if (win_i) begin
                    mem_addr = i_addr;
                end
                if (win_i || win_d) begin
                    state_d = WAIT;
                    owner_d = win_d;
                    last_d  = win_d;
                    addr_d  = mem_addr;
                end
            end
            WAIT: begin
                i_rvalid = !owner_q;
                d_rvalid = owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are quiet for the whole reset cycle, including a cancelled WAIT
        if (rst) begin
            win_i    = 1'b0;
            win_d    = 1'b0;
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
            mem_we   = 1'b0;
            mem_wd   = 32'h0;
            mem_addr = 32'h0;
        end
        i_gnt   = win_i;
        d_gnt   = win_d;
        i_rdata = i_rvalid ? mem_rd : 32'h0;
        d_rdata = d_rvalid ? mem_rd : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter against a transaction-level model.
// A second instance with FIXED_PRIO=1 is checked under a held conflict.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wd;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd;
    logic [31:0] mem_rd;

    logic        fp_i_gnt, fp_i_rvalid, fp_d_gnt, fp_d_rvalid, fp_mem_we;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_addr, fp_mem_wd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit keep = 1'b0;
    bit i_took = 1'b0;
    bit d_took = 1'b0;

    logic [31:0] env_mem [8];
    logic [31:0] ref_mem [8];

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } resp_t;
    resp_t sb[$];

    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    logic [31:0] m_addr = 32'h0;

    mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .i_req(1'b1), .i_addr(32'h0000_0040), .i_gnt(fp_i_gnt),
        .i_rvalid(fp_i_rvalid), .i_rdata(fp_i_rdata),
        .d_req(1'b1), .d_we(1'b0), .d_addr(32'h0000_0080),
        .d_wd(32'h0), .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid),
        .d_rdata(fp_d_rdata), .mem_we(fp_mem_we),
        .mem_addr(fp_mem_addr), .mem_wd(fp_mem_wd),
        .mem_rd(32'h1234_5678)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] env_rd(logic [31:0] a);
        return (a[31:5] == 27'h0) ? env_mem[a[4:2]] : (a ^ 32'h5A5A_5A5A);
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return (a[31:5] == 27'h0) ? ref_mem[a[4:2]] : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Memory environment: read data is returned one cycle after the address
    always @(posedge clk) begin
        mem_rd <= env_rd(mem_addr);
        if (mem_we && mem_addr[31:5] == 27'h0)
            env_mem[mem_addr[4:2]] <= mem_wd;
    end

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // Reference model: at most one grant per two cycles, ties alternate
    always @(negedge clk) begin
        bit          wi, wd;
        logic [31:0] data;
        wi = 1'b0;
        wd = 1'b0;
        if (rst) begin
            check("rst_ctrl", {i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid}, 32'h0);
            check("rst_bus", mem_addr | mem_wd | i_rdata | d_rdata, 32'h0);
            m_busy = 1'b0;
            m_last = 1'b1;
            sb.delete();
        end else if (m_busy) begin
            check("wait_gnt", {i_gnt, d_gnt, mem_we}, 32'h0);
            check("wait_addr", mem_addr, m_addr);
            m_busy = 1'b0;
        end else begin
            if (i_req && d_req) begin
                wd = !m_last;
                wi = m_last;
            end else begin
                wd = d_req;
                wi = i_req;
            end
            check("gnt", {i_gnt, d_gnt}, {wi, wd});
            check("mem_we", mem_we, wd && d_we);
            check("mem_wd", mem_wd, wd ? d_wd : 32'h0);
            if (wi || wd) begin
                m_addr = wd ? d_addr : i_addr;
                check("gnt_addr", mem_addr, m_addr);
                data = ref_rd(m_addr);
                if (wd && d_we && m_addr[31:5] == 27'h0)
                    ref_mem[m_addr[4:2]] = d_wd;
                m_busy = 1'b1;
                m_last = wd;
                sb.push_back('{wd, data, cyc});
            end
        end
        i_took = i_gnt;
        d_took = d_gnt;
    end

    // Response monitor
    always @(negedge clk) begin
        resp_t r;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                r = sb.pop_front();
                check("rvalid", {i_rvalid, d_rvalid}, r.port ? 32'h1 : 32'h2);
                check("rdata", r.port ? d_rdata : i_rdata, r.data);
            end else begin
                check("no_rvalid", {i_rvalid, d_rvalid}, 32'h0);
            end
            check("rdata_zero", (i_rvalid ? 32'h0 : i_rdata) |
                  (d_rvalid ? 32'h0 : d_rdata), 32'h0);
        end
    end

    // FIXED_PRIO=1: data wins every IDLE cycle after the first reset release
    initial begin
        @(negedge rst);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fp_i_gnt", fp_i_gnt, 32'h0);
            check("fp_d_gnt", fp_d_gnt, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (i_took && !keep) i_req = 1'b0;
        if (d_took && !keep) d_req = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            env_mem[k] = 32'h1000 + k * 32'h0101_0101;
            ref_mem[k] = 32'h1000 + k * 32'h0101_0101;
        end
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wd = 32'h0;
        repeat (3) step();
        rst = 1'b0;

        i_req = 1'b1; i_addr = 32'h0001_0004;
        repeat (3) step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0010; d_wd = 32'hDEAD_BEEF;
        repeat (3) step();
        d_req = 1'b1; d_we = 1'b0;
        repeat (3) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        keep = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_0008;
        d_req = 1'b1; d_addr = 32'h0000_000C;
        repeat (8) step();
        keep = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) step();

        i_req = 1'b1; i_addr = 32'h0000_0014;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0018;
        repeat (2) step();

        keep = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_001C;
        repeat (6) step();
        keep = 1'b0;
        i_req = 1'b0;
        repeat (2) step();

        for (int n = 0; n < 500; n++) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                i_addr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            end else if (i_req && !i_took && $urandom_range(0, 15) == 0) begin
                i_req = 1'b0;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
                d_wd = $urandom;
            end else if (d_req && !d_took && $urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin between ports, 1 = data port always wins a conflict.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_req, input, 1, instruction-fetch read request.
REQ-005 SHALL have port i_addr, input, 32, instruction-fetch byte address.
REQ-006 SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have port i_rvalid, output, 1, fetch read data valid this cycle.
REQ-008 SHALL have port i_rdata, output, 32, fetch read data.
REQ-009 SHALL have port d_req, input, 1, data-port request.
REQ-010 SHALL have port d_we, input, 1, data-port write (1) or read (0).
REQ-011 SHALL have port d_addr, input, 32, data-port byte address.
REQ-012 SHALL have port d_wd, input, 32, data-port write data.
REQ-013 SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-014 SHALL have port d_rvalid, output, 1, data access complete; read data valid if a read.
REQ-015 SHALL have port d_rdata, output, 32, data-port read data.
REQ-016 SHALL have port mem_we, output, 1, write enable to memory interface.
REQ-017 SHALL have port mem_addr, output, 32, address to memory interface.
REQ-018 SHALL have port mem_wd, output, 32, write data to memory interface.
REQ-019 SHALL have port mem_rd, input, 32, memory read data, valid one cycle after the address is presented, with the address held.

Function
REQ-020 SHALL implement FSM states IDLE and WAIT, plus a 1-bit owner register (0 = fetch, 1 = data) and a 1-bit last-grant register.
REQ-021 In IDLE with any request pending, SHALL assert exactly one gnt combinationally in that cycle, drive mem_addr from the winner, and go to WAIT.
REQ-022 In IDLE with no request, SHALL keep both gnts 0 and mem_we 0, and stay in IDLE.
REQ-023 On conflict (i_req and d_req both 1), with FIXED_PRIO=0, SHALL grant the port not granted most recently; with FIXED_PRIO=1, SHALL always grant data.
REQ-024 With a single requester, SHALL grant it regardless of the last-grant value.
REQ-025 SHALL update last-grant only on a grant cycle.
REQ-026 mem_we SHALL equal d_we only in a data-grant cycle, and SHALL be 0 in every other cycle, including all of WAIT.
REQ-027 mem_wd SHALL equal d_wd in a data-grant cycle and 0 otherwise.
REQ-028 In WAIT, SHALL hold mem_addr at the registered granted address, assert no gnt, assert the owner's rvalid, and return to IDLE.
REQ-029 Throughput: one access per 2 cycles; a request presented in the WAIT cycle SHALL be considered in the next IDLE cycle.
REQ-030 i_rdata/d_rdata SHALL equal mem_rd while the respective rvalid is 1, and 0 otherwise.
REQ-031 d_rvalid SHALL also assert for writes, as a completion acknowledgement.
REQ-032 Requesters hold req/addr/we/wd stable until gnt; the arbiter SHALL sample them only in the grant cycle.
REQ-033 A req deasserted before gnt SHALL be dropped, with no memory access and no rvalid.

Reset
REQ-034 While rst=1 at a clock edge, SHALL enter IDLE with last-grant=1 (fetch wins the first conflict), registered address 0, and owner 0.
REQ-035 During reset cycles, all gnt, rvalid and mem_we SHALL be 0, and mem_addr, mem_wd and rdata SHALL be 0.
REQ-036 Reset asserted in WAIT SHALL cancel the pending response, so no rvalid is issued after reset.

Verification
REQ-037 Single fetch: i_req=1, i_addr=0x00010004, mem_rd=0x00500093 -> cycle0 i_gnt=1, mem_addr=0x00010004; cycle1 i_rvalid=1, i_rdata=0x00500093, mem_addr held.
REQ-038 Data write: d_req=1, d_we=1, d_addr=0x00100010, d_wd=0xDEADBEEF -> cycle0 d_gnt=1, mem_we=1, mem_wd=0xDEADBEEF; cycle1 mem_we=0, d_rvalid=1.
REQ-039 Conflict after reset, FIXED_PRIO=0, both requests held -> grants fetch, data, fetch, data on cycles 0, 2, 4, 6.
REQ-040 Conflict, FIXED_PRIO=1, both requests held -> d_gnt on every IDLE cycle and i_gnt never.
REQ-041 Reset mid-access: rst=1 in the WAIT cycle of a fetch -> i_rvalid=0 and state IDLE; next i_req is granted the cycle after rst falls.
REQ-042 Back-to-back fetch with i_req held -> i_gnt on alternate cycles, and i_rvalid on the cycles in between.
